// File: rtl/line_buffer_ctrl.sv
// Upstream controller for the 3-line BRAM line buffer: AXI4-Stream pixels in, buffer write/read ports and window strobe out.
// Optional line-length error checking is compiled in when LBC_ERR_CHECK_EN is defined.
module line_buffer_ctrl #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned LINE_WIDTH   = 1920,
   parameter int unsigned FRAME_HEIGHT = 1080
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tuser,
   input  logic                  s_axis_tlast,
   output logic                  lb_en_wr,
   output logic [DATA_WIDTH-1:0] lb_pixel_in,
   output logic [10:0]           lb_write_x,
   output logic [1:0]            lb_write_row,
   output logic                  lb_en_rd,
   output logic [10:0]           lb_read_x,
   output logic [10:0]           lb_read_y,
   output logic                  win_valid,
   output logic [10:0]           win_x,
   output logic [10:0]           win_y,
   output logic                  win_sof,
   output logic                  win_eol,
   output logic                  err_short_line,
   output logic                  err_long_line
);

   localparam int unsigned CW = 11;
   localparam logic [CW-1:0] X_LAST = CW'(LINE_WIDTH - 1);
   localparam logic [CW-1:0] X_PEN  = CW'(LINE_WIDTH - 2);
   localparam logic [CW-1:0] Y_LAST = CW'(FRAME_HEIGHT - 1);

`ifdef LBC_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      FLUSH  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         x_q, x_d;
   logic [CW-1:0]         y_q, y_d;
   logic [1:0]            row_q, row_d;
   logic                  flush_q, flush_d;
   logic                  drop_q, drop_d;
   logic                  err_short_q, err_short_d;
   logic                  err_long_q, err_long_d;

   logic                  en_wr_q, en_wr_d;
   logic [DATA_WIDTH-1:0] pixel_q, pixel_d;
   logic [CW-1:0]         wr_x_q, wr_x_d;
   logic [1:0]            wr_row_q, wr_row_d;
   logic                  en_rd_q, en_rd_d;
   logic [CW-1:0]         rd_x_q, rd_x_d;
   logic [CW-1:0]         rd_y_q, rd_y_d;
   logic                  win_valid_q, win_valid_d;
   logic [CW-1:0]         win_x_q, win_x_d;
   logic [CW-1:0]         win_y_q, win_y_d;
   logic                  win_sof_q, win_sof_d;
   logic                  win_eol_q, win_eol_d;

   logic                  accept_c;
   logic                  line_done_c;
   logic [1:0]            row_nxt_c;

   assign s_axis_tready = !rst && (state_q != FLUSH);
   assign accept_c      = s_axis_tvalid && s_axis_tready;
   assign row_nxt_c     = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;

   // Next-state, position tracking and buffer port control
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      row_d       = row_q;
      flush_d     = flush_q;
      drop_d      = drop_q;
      err_short_d = err_short_q;
      err_long_d  = err_long_q;
      en_wr_d     = 1'b0;
      pixel_d     = pixel_q;
      wr_x_d      = wr_x_q;
      wr_row_d    = wr_row_q;
      en_rd_d     = 1'b0;
      rd_x_d      = rd_x_q;
      rd_y_d      = rd_y_q;
      line_done_c = 1'b0;

      // Window strobe trails the read request by the buffer's read latency
      win_valid_d = en_rd_q;
      win_x_d     = rd_x_q;
      win_y_d     = rd_y_q + CW'(1);
      win_sof_d   = en_rd_q && (rd_x_q == '0) && (rd_y_q == '0);
      win_eol_d   = en_rd_q && (rd_x_q == X_LAST);

      if (accept_c && s_axis_tuser) begin
         state_d     = FILL;
         x_d         = CW'(1);
         y_d         = '0;
         row_d       = 2'd0;
         flush_d     = 1'b0;
         drop_d      = 1'b0;
         err_short_d = 1'b0;
         err_long_d  = 1'b0;
         en_wr_d     = 1'b1;
         pixel_d     = s_axis_tdata;
         wr_x_d      = '0;
         wr_row_d    = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            FILL, STREAM: begin
               if (accept_c) begin
                  if (drop_q) begin
                     line_done_c = s_axis_tlast;
                  end else begin
                     en_wr_d  = 1'b1;
                     pixel_d  = s_axis_tdata;
                     wr_x_d   = x_q;
                     wr_row_d = row_q;
                     // Centre x-2 only needs columns up to x-1 of the current row
                     if ((state_q == STREAM) && (x_q >= CW'(2))) begin
                        en_rd_d = 1'b1;
                        rd_x_d  = x_q - CW'(2);
                        rd_y_d  = y_q - CW'(2);
                     end
                     if (x_q == X_LAST) begin
                        if (ERR_EN && !s_axis_tlast) begin
                           err_long_d = 1'b1;
                           drop_d     = 1'b1;
                        end else begin
                           line_done_c = 1'b1;
                        end
                     end else if (ERR_EN && s_axis_tlast) begin
                        err_short_d = 1'b1;
                        line_done_c = 1'b1;
                     end else begin
                        x_d = x_q + CW'(1);
                     end
                  end
               end
            end
            FLUSH: begin
               en_rd_d = 1'b1;
               rd_x_d  = flush_q ? X_LAST : X_PEN;
               rd_y_d  = y_q - CW'(2);
               flush_d = ~flush_q;
               if (flush_q) begin
                  x_d = '0;
                  if (y_q == Y_LAST) begin
                     state_d = IDLE;
                     y_d     = '0;
                     row_d   = 2'd0;
                  end else begin
                     state_d = STREAM;
                     y_d     = y_q + CW'(1);
                     row_d   = row_nxt_c;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         if (line_done_c) begin
            drop_d = 1'b0;
            if (state_q == STREAM) begin
               state_d = FLUSH;
               flush_d = 1'b0;
            end else begin
               x_d   = '0;
               y_d   = y_q + CW'(1);
               row_d = row_nxt_c;
               if (y_q == CW'(1)) begin
                  state_d = STREAM;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         row_q       <= 2'd0;
         flush_q     <= 1'b0;
         drop_q      <= 1'b0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         en_wr_q     <= 1'b0;
         pixel_q     <= '0;
         wr_x_q      <= '0;
         wr_row_q    <= 2'd0;
         en_rd_q     <= 1'b0;
         rd_x_q      <= '0;
         rd_y_q      <= '0;
         win_valid_q <= 1'b0;
         win_x_q     <= '0;
         win_y_q     <= '0;
         win_sof_q   <= 1'b0;
         win_eol_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         row_q       <= row_d;
         flush_q     <= flush_d;
         drop_q      <= drop_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
         en_wr_q     <= en_wr_d;
         pixel_q     <= pixel_d;
         wr_x_q      <= wr_x_d;
         wr_row_q    <= wr_row_d;
         en_rd_q     <= en_rd_d;
         rd_x_q      <= rd_x_d;
         rd_y_q      <= rd_y_d;
         win_valid_q <= win_valid_d;
         win_x_q     <= win_x_d;
         win_y_q     <= win_y_d;
         win_sof_q   <= win_sof_d;
         win_eol_q   <= win_eol_d;
      end
   end

   assign lb_en_wr       = en_wr_q;
   assign lb_pixel_in    = pixel_q;
   assign lb_write_x     = wr_x_q;
   assign lb_write_row   = wr_row_q;
   assign lb_en_rd       = en_rd_q;
   assign lb_read_x      = rd_x_q;
   assign lb_read_y      = rd_y_q;
   assign win_valid      = win_valid_q;
   assign win_x          = win_x_q;
   assign win_y          = win_y_q;
   assign win_sof        = win_sof_q;
   assign win_eol        = win_eol_q;
   assign err_short_line = err_short_q;
   assign err_long_line  = err_long_q;

endmodule
